// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash boot loader: register map, CTRL bit layout,
// flash opcode and the sequencer state encoding.
package spi_pkg;

    localparam logic [31:0] SPI_CTRL   = 32'h0000_0000;
    localparam logic [31:0] SPI_DATA   = 32'h0000_0004;
    localparam logic [31:0] SPI_STATUS = 32'h0000_0008;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CPOL_BIT  = 1;
    localparam int CTRL_CPHA_BIT  = 2;
    localparam int CTRL_SS_BIT    = 3;
    localparam int CTRL_DIV_LSB   = 8;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_TX,
        ST_KICK,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_CAPTURE,
        ST_MEM_WR,
        ST_CS_OFF,
        ST_DONE,
        ST_ERR
    } spi_state_e;

    // Mode 0 transfer start with slave select held asserted.
    function automatic logic [31:0] ctrl_kick(input logic [7:0] div);
        logic [31:0] w;
        w                              = 32'h0;
        w[CTRL_DIV_LSB +: 8]           = div;
        w[CTRL_SS_BIT]                 = 1'b1;
        w[CTRL_CPHA_BIT]               = 1'b0;
        w[CTRL_CPOL_BIT]               = 1'b0;
        w[CTRL_START_BIT]              = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One SPI byte exchange over the peripheral register bus: DATA write, CTRL kick,
// STATUS busy handshake, DATA read-back. Optional SPI_LOADER_TIMEOUT_EN aborts stalled waits.
module spi_byte_xfer
    import spi_pkg::*;
#(
    parameter logic [7:0] CLK_DIV = 8'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [7:0]  i_tx_byte,
    input  logic [31:0] i_spi_data,
    output logic [31:0] o_spi_addr,
    output logic [31:0] o_spi_data,
    output logic        o_spi_wr_en,
    output logic        o_ack,
    output logic [7:0]  o_rx_byte,
    output logic        o_tmo
);

    spi_state_e r_state;
    spi_state_e w_next;
    logic [7:0] r_tx;
    logic       w_unused_hi;

    assign w_unused_hi = &{1'b0, i_spi_data[31:8]};
    assign o_rx_byte   = i_spi_data[7:0];

`ifdef SPI_LOADER_TIMEOUT_EN
    localparam logic [15:0] TMO_CYCLES = 16'hFFFF;
    logic [15:0] r_tmo_cnt;
    logic        w_waiting;
    logic        w_tmo_hit;

    assign w_waiting = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);
    // Count starts at 0 on the first wait cycle, so the hit fires on cycle TMO_CYCLES.
    assign w_tmo_hit = w_waiting && (r_tmo_cnt == TMO_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n || (w_next != r_state)) begin
            r_tmo_cnt <= '0;
        end else if (w_waiting) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (i_req) begin
            r_tx <= i_tx_byte;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_spi_addr  = SPI_CTRL;
        o_spi_data  = 32'h0;
        o_spi_wr_en = 1'b0;
        o_ack       = 1'b0;
        o_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req) w_next = ST_LOAD_TX;
            end
            ST_LOAD_TX: begin
                o_spi_addr  = SPI_DATA;
                o_spi_data  = {24'h0, r_tx};
                o_spi_wr_en = 1'b1;
                w_next      = ST_KICK;
            end
            ST_KICK: begin
                o_spi_addr  = SPI_CTRL;
                o_spi_data  = ctrl_kick(CLK_DIV);
                o_spi_wr_en = 1'b1;
                w_next      = ST_WAIT_HI;
            end
            // STATUS still reads the pre-kick 0 for a cycle; only a seen 1 arms the fall detect.
            ST_WAIT_HI: begin
                o_spi_addr = SPI_STATUS;
                if (i_spi_data[0]) begin
                    w_next = ST_WAIT_LO;
                end
`ifdef SPI_LOADER_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    o_tmo  = 1'b1;
                    w_next = ST_IDLE;
                end
`endif
            end
            ST_WAIT_LO: begin
                o_spi_addr = SPI_STATUS;
                if (!i_spi_data[0]) begin
                    w_next = ST_CAPTURE;
                end
`ifdef SPI_LOADER_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    o_tmo  = 1'b1;
                    w_next = ST_IDLE;
                end
`endif
            end
            ST_CAPTURE: begin
                o_spi_addr = SPI_DATA;
                o_ack      = 1'b1;
                w_next     = i_req ? ST_LOAD_TX : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/spi_flash_loader.sv
// Boot loader: streams WORD_COUNT words from SPI flash into memory while holding the CPU.
// Define SPI_LOADER_TIMEOUT_EN to abort to ERR when the SPI peripheral stalls.
module spi_flash_loader
    import spi_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter int unsigned WORD_COUNT = 1024,
    parameter logic [7:0]  CLK_DIV    = 8'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        hold_o,
    output logic [31:0] spi_addr_o,
    output logic [31:0] spi_data_o,
    output logic        spi_wr_en_o,
    input  logic [31:0] spi_data_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_we_o
);

    localparam logic [15:0] LAST_WORD = 16'(WORD_COUNT - 1);
    localparam logic [2:0]  HDR_DONE  = 3'd4;

    spi_state_e  r_state;
    spi_state_e  w_next;
    logic [2:0]  r_hdr_idx;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_word_idx;
    logic [31:0] r_word;
    logic        w_start;
    logic        w_req;
    logic [7:0]  w_tx_byte;
    logic        w_ack;
    logic        w_tmo;
    logic [7:0]  w_rx_byte;
    logic [31:0] w_xfer_addr;
    logic [31:0] w_xfer_data;
    logic        w_xfer_wr;
    logic        w_data_byte;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return FLASH_CMD_READ;
            3'd1:    return FLASH_BASE[23:16];
            3'd2:    return FLASH_BASE[15:8];
            3'd3:    return FLASH_BASE[7:0];
            default: return 8'h00;
        endcase
    endfunction

    spi_byte_xfer #(
        .CLK_DIV (CLK_DIV)
    ) u_xfer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (w_req),
        .i_tx_byte   (w_tx_byte),
        .i_spi_data  (spi_data_i),
        .o_spi_addr  (w_xfer_addr),
        .o_spi_data  (w_xfer_data),
        .o_spi_wr_en (w_xfer_wr),
        .o_ack       (w_ack),
        .o_rx_byte   (w_rx_byte),
        .o_tmo       (w_tmo)
    );

    assign w_start     = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERR));
    assign w_data_byte = (r_hdr_idx == HDR_DONE);

`ifdef SPI_LOADER_TIMEOUT_EN
    logic r_abort;

    always_ff @(posedge clk) begin
        if (!rst_n || w_start) begin
            r_abort <= 1'b0;
        end else if ((r_state == ST_LOAD_TX) && w_tmo) begin
            r_abort <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hdr_idx  <= '0;
            r_byte_cnt <= '0;
            r_word_idx <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_hdr_idx  <= '0;
                r_byte_cnt <= '0;
                r_word_idx <= '0;
            end else if ((r_state == ST_LOAD_TX) && w_ack) begin
                if (w_data_byte) begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end else begin
                    r_hdr_idx <= r_hdr_idx + 3'd1;
                end
            end else if (r_state == ST_MEM_WR) begin
                r_word_idx <= r_word_idx + 16'd1;
            end
        end
    end

    // Little-endian assembly: first data byte of a word lands in [7:0].
    always_ff @(posedge clk) begin
        if ((r_state == ST_LOAD_TX) && w_ack && w_data_byte) begin
            r_word[{r_byte_cnt, 3'b000} +: 8] <= w_rx_byte;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_tx_byte = 8'h00;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    w_req     = 1'b1;
                    w_tx_byte = FLASH_CMD_READ;
                    w_next    = ST_LOAD_TX;
                end
            end
            ST_LOAD_TX: begin
                if (w_tmo) begin
                    w_next = ST_CS_OFF;
                end else if (w_ack) begin
                    if (w_data_byte && (r_byte_cnt == 2'd3)) begin
                        w_next = ST_MEM_WR;
                    end else begin
                        w_req     = 1'b1;
                        w_tx_byte = hdr_byte(3'(r_hdr_idx + 3'd1));
                    end
                end
            end
            ST_MEM_WR: begin
                if (r_word_idx == LAST_WORD) begin
                    w_next = ST_CS_OFF;
                end else begin
                    w_req  = 1'b1;
                    w_next = ST_LOAD_TX;
                end
            end
            ST_CS_OFF: begin
`ifdef SPI_LOADER_TIMEOUT_EN
                w_next = r_abort ? ST_ERR : ST_DONE;
`else
                w_next = ST_DONE;
`endif
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy_o   = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign done_o   = (r_state == ST_DONE);
    assign hold_o   = !((r_state == ST_DONE) || (r_state == ST_ERR));
`ifdef SPI_LOADER_TIMEOUT_EN
    assign err_o    = (r_state == ST_ERR);
`else
    assign err_o    = 1'b0;
`endif

    assign mem_we_o   = (r_state == ST_MEM_WR);
    assign mem_addr_o = mem_we_o ? (MEM_BASE + {14'b0, r_word_idx, 2'b00}) : 32'h0;
    assign mem_data_o = mem_we_o ? r_word : 32'h0;

    // CS release writes CTRL=0 while the byte engine is idle.
    assign spi_wr_en_o = w_xfer_wr || (r_state == ST_CS_OFF);
    assign spi_addr_o  = (r_state == ST_CS_OFF) ? SPI_CTRL : w_xfer_addr;
    assign spi_data_o  = (r_state == ST_CS_OFF) ? 32'h0 : w_xfer_data;

endmodule
